// File: rtl/cipher_pkg.sv
// Shared definitions for the cipher-core arbiter: FSM state encoding, port IDs,
// cipher mode constants and the two-way round-robin pick function.
package cipher_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    GRANT = 3'b001,
    RUN   = 3'b010,
    RESP  = 3'b011,
    DRAIN = 3'b100
  } state_e;

  localparam logic CODE_PORT = 1'b0;
  localparam logic DATA_PORT = 1'b1;

  localparam logic MODE_DEC = 1'b0;
  localparam logic MODE_ENC = 1'b1;

  // req[0] is the code side, req[1] the data side; a tie goes to the port
  // that did not own the core last.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_owner);
    logic pick;
    unique case (req)
      2'b01:   pick = CODE_PORT;
      2'b10:   pick = DATA_PORT;
      2'b11:   pick = ~last_owner;
      default: pick = CODE_PORT;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational pick from the request pair and a
// registered last-owner bit that the caller updates when an ownership ends.
module rr_arbiter2
  import cipher_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       owner_i,
  output logic       valid_o,
  output logic       pick_o
);

  logic last_owner_q;

  // Reset to the data port so the code port wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_owner_q <= DATA_PORT;
    end else if (update_i) begin
      last_owner_q <= owner_i;
    end
  end

  always_comb begin
    valid_o = |req_i;
    pick_o  = rr_pick(req_i, last_owner_q);
  end

endmodule

// File: rtl/cipher_arbiter.sv
// Shares one block-cipher core between the code-fetch and data load/store
// requesters: round-robin grant, operand steering, abort/drain and watchdog.
module cipher_arbiter
  import cipher_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CNT_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_req,
  input  logic              code_mode,
  input  logic [DATA_W-1:0] code_din,
  input  logic              code_abort,
  input  logic              data_req,
  input  logic              data_mode,
  input  logic [DATA_W-1:0] data_din,
  input  logic              data_abort,
  input  logic              core_busy,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_dout,
  output logic              code_gnt,
  output logic              data_gnt,
  output logic              code_done,
  output logic              data_done,
  output logic [DATA_W-1:0] dout,
  output logic              core_start,
  output logic              core_mode,
  output logic [DATA_W-1:0] core_din,
  output logic              core_abort,
  output logic              timeout_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e            state_q;
  logic              owner_q;
  logic              core_start_q;
  logic              core_mode_q;
  logic [DATA_W-1:0] core_din_q;
  logic              core_abort_q;
  logic [DATA_W-1:0] dout_q;
  logic              code_done_q;
  logic              data_done_q;
  logic              timeout_err_q;
  logic [CNT_W-1:0]  wdog_q;

  logic arb_valid;
  logic arb_pick;
  logic arb_update;
  logic own_req;
  logic own_abort;
  logic owns_core;

  assign own_req    = (owner_q == DATA_PORT) ? data_req   : code_req;
  assign own_abort  = (owner_q == DATA_PORT) ? data_abort : code_abort;
  assign arb_update = (state_q == RESP) || ((state_q == DRAIN) && !core_busy);

  rr_arbiter2 u_rr (
    .clk_i    (clk),
    .rst_i    (reset),
    .req_i    ({data_req, code_req}),
    .update_i (arb_update),
    .owner_i  (owner_q),
    .valid_o  (arb_valid),
    .pick_o   (arb_pick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= CODE_PORT;
      core_start_q  <= 1'b0;
      core_mode_q   <= MODE_DEC;
      core_din_q    <= '0;
      core_abort_q  <= 1'b0;
      dout_q        <= '0;
      code_done_q   <= 1'b0;
      data_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      wdog_q        <= '0;
    end else begin
      core_start_q <= 1'b0;
      code_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (arb_valid) begin
            owner_q     <= arb_pick;
            core_mode_q <= (arb_pick == DATA_PORT) ? data_mode : code_mode;
            core_din_q  <= (arb_pick == DATA_PORT) ? data_din  : code_din;
            state_q     <= GRANT;
          end
        end
        GRANT: begin
          core_start_q <= 1'b1;
          wdog_q       <= '0;
          state_q      <= RUN;
        end
        RUN: begin
          wdog_q <= wdog_q + 1'b1;
          // Abort and withdrawal outrank a same-cycle core_done; that result is dropped.
          if (own_abort || !own_req) begin
            core_abort_q <= 1'b1;
            state_q      <= DRAIN;
          end else if (wdog_q == TIMEOUT_C) begin
            timeout_err_q <= 1'b1;
            core_abort_q  <= 1'b1;
            state_q       <= DRAIN;
          end else if (core_done) begin
            dout_q <= core_dout;
            if (owner_q == DATA_PORT) begin
              data_done_q <= 1'b1;
            end else begin
              code_done_q <= 1'b1;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        DRAIN: begin
          if (!core_busy) begin
            core_abort_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign owns_core   = (state_q == GRANT) || (state_q == RUN) || (state_q == RESP);
  assign code_gnt    = owns_core && (owner_q == CODE_PORT);
  assign data_gnt    = owns_core && (owner_q == DATA_PORT);
  assign code_done   = code_done_q;
  assign data_done   = data_done_q;
  assign dout        = dout_q;
  assign core_start  = core_start_q;
  assign core_mode   = core_mode_q;
  assign core_din    = core_din_q;
  assign core_abort  = core_abort_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_cipher_arbiter.sv
// Scenario bench for cipher_arbiter: expected launches and results are queued
// when stimulus is driven and popped when the DUT produces start/done.
module tb_cipher_arbiter;
  import cipher_pkg::*;

  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          code_req, code_mode, code_abort;
  logic [DW-1:0] code_din;
  logic          data_req, data_mode, data_abort;
  logic [DW-1:0] data_din;
  logic          core_busy, core_done;
  logic [DW-1:0] core_dout;

  logic          code_gnt, data_gnt, code_done, data_done, core_start, core_mode, core_abort, timeout_err;
  logic [DW-1:0] dout, core_din;
  logic          t_code_gnt, t_data_gnt, t_code_done, t_data_done, t_core_start, t_core_mode, t_core_abort, t_timeout_err;
  logic [DW-1:0] t_dout, t_core_din;

  cipher_arbiter #(.DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .code_req(code_req), .code_mode(code_mode), .code_din(code_din), .code_abort(code_abort),
    .data_req(data_req), .data_mode(data_mode), .data_din(data_din), .data_abort(data_abort),
    .core_busy(core_busy), .core_done(core_done), .core_dout(core_dout),
    .code_gnt(code_gnt), .data_gnt(data_gnt), .code_done(code_done), .data_done(data_done),
    .dout(dout), .core_start(core_start), .core_mode(core_mode), .core_din(core_din),
    .core_abort(core_abort), .timeout_err(timeout_err)
  );

  cipher_arbiter #(.DATA_W(DW), .TIMEOUT(15), .CNT_W(4)) dut_to (
    .clk(clk), .reset(reset),
    .code_req(code_req), .code_mode(code_mode), .code_din(code_din), .code_abort(code_abort),
    .data_req(data_req), .data_mode(data_mode), .data_din(data_din), .data_abort(data_abort),
    .core_busy(core_busy), .core_done(core_done), .core_dout(core_dout),
    .code_gnt(t_code_gnt), .data_gnt(t_data_gnt), .code_done(t_code_done), .data_done(t_data_done),
    .dout(t_dout), .core_start(t_core_start), .core_mode(t_core_mode), .core_din(t_core_din),
    .core_abort(t_core_abort), .timeout_err(t_timeout_err)
  );

  typedef struct {
    logic          port;
    logic          mode;
    logic [DW-1:0] val;
  } exp_t;

  exp_t          start_q[$];
  exp_t          res_q[$];
  exp_t          e;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] last_res;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    code_req = 1'b0; code_mode = 1'b0; code_abort = 1'b0; code_din = '0;
    data_req = 1'b0; data_mode = 1'b0; data_abort = 1'b0; data_din = '0;
    core_busy = 1'b0; core_done = 1'b0; core_dout = '0;
    start_q.delete();
    res_q.delete();
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  task automatic wait_start(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      cyc();
      if (core_start === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({code_gnt, data_gnt, code_done, data_done, core_start, core_mode, core_abort, timeout_err} !== 8'h00
        || dout !== '0 || core_din !== '0) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b dout=%h core_din=%h, required all zero",
               {code_gnt, data_gnt, code_done, data_done, core_start, core_mode, core_abort, timeout_err}, dout, core_din);
    end
    checks++;
    if ({t_code_gnt, t_data_gnt, t_code_done, t_data_done, t_core_start, t_core_mode, t_core_abort, t_timeout_err} !== 8'h00
        || t_dout !== '0 || t_core_din !== '0) begin
      errors++;
      $display("FAIL reset_outputs_to: flags=%b dout=%h core_din=%h, required all zero",
               {t_code_gnt, t_data_gnt, t_code_done, t_data_done, t_core_start, t_core_mode, t_core_abort, t_timeout_err}, t_dout, t_core_din);
    end
  endtask

  task automatic test_single();
    bit bad;
    code_mode = MODE_ENC;
    code_din  = 64'h0123456789ABCDEF;
    code_req  = 1'b1;
    start_q.push_back('{CODE_PORT, MODE_ENC, 64'h0123456789ABCDEF});
    res_q.push_back('{CODE_PORT, MODE_ENC, 64'hDEADBEEFCAFEF00D});
    cyc();
    checks++;
    if (core_start !== 1'b0 || code_gnt !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: core_start=%b code_gnt=%b, required 0 and 1", core_start, code_gnt);
    end
    cyc();
    checks++;
    if (core_start !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: core_start=%b two cycles after req, required 1", core_start);
    end
    e = start_q.pop_front();
    checks++;
    if (core_din !== e.val || core_mode !== e.mode || data_gnt !== 1'b0) begin
      errors++;
      $display("FAIL single_operand: din=%h mode=%b data_gnt=%b, required %h %b 0", core_din, core_mode, data_gnt, e.val, e.mode);
    end
    core_busy = 1'b1;
    bad = 1'b0;
    repeat (19) begin
      cyc();
      if (code_done !== 1'b0 || data_gnt !== 1'b0 || code_gnt !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL single_run: early done or wrong grant during RUN, required code_gnt=1 only");
    end
    core_done = 1'b1;
    core_dout = 64'hDEADBEEFCAFEF00D;
    cyc();
    core_done = 1'b0;
    core_busy = 1'b0;
    e = res_q.pop_front();
    checks++;
    if (code_done !== 1'b1 || data_done !== 1'b0 || dout !== e.val) begin
      errors++;
      $display("FAIL single_done: code_done=%b data_done=%b dout=%h, required 1 0 %h", code_done, data_done, dout, e.val);
    end
    code_req = 1'b0;
    cyc();
    checks++;
    if (code_done !== 1'b0 || dout !== 64'hDEADBEEFCAFEF00D) begin
      errors++;
      $display("FAIL single_hold: code_done=%b dout=%h, required 0 deadbeefcafef00d", code_done, dout);
    end
  endtask

  task automatic test_rr();
    bit seen;
    logic [DW-1:0] val;
    apply_reset();
    code_mode = MODE_ENC; code_din = 64'h1111_2222_3333_4444;
    data_mode = MODE_DEC; data_din = 64'h5555_6666_7777_8888;
    code_req = 1'b1;
    data_req = 1'b1;
    start_q.push_back('{CODE_PORT, MODE_ENC, 64'h1111_2222_3333_4444});
    start_q.push_back('{DATA_PORT, MODE_DEC, 64'h5555_6666_7777_8888});
    start_q.push_back('{CODE_PORT, MODE_ENC, 64'h1111_2222_3333_4444});
    for (int k = 0; k < 3; k++) begin
      wait_start(6, seen);
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL rr_start_%0d: core_start=%b within 6 cycles, required 1", k, core_start);
      end
      e = start_q.pop_front();
      checks++;
      if (core_din !== e.val || core_mode !== e.mode || {data_gnt, code_gnt} !== (e.port ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_grant_%0d: gnt(d,c)=%b%b din=%h mode=%b, required port %0d din=%h mode=%b",
                 k, data_gnt, code_gnt, core_din, core_mode, e.port, e.val, e.mode);
      end
      val = 64'hC0DE_0000_0000_0000 | 64'(k + 1);
      res_q.push_back('{e.port, e.mode, val});
      core_busy = 1'b1;
      repeat (3) cyc();
      core_done = 1'b1;
      core_dout = val;
      cyc();
      core_done = 1'b0;
      core_busy = 1'b0;
      e = res_q.pop_front();
      checks++;
      if ({data_done, code_done} !== (e.port ? 2'b10 : 2'b01) || dout !== e.val) begin
        errors++;
        $display("FAIL rr_done_%0d: done(d,c)=%b%b dout=%h, required port %0d dout=%h",
                 k, data_done, code_done, dout, e.port, e.val);
      end
      last_res = e.val;
    end
    code_req = 1'b0;
    data_req = 1'b0;
    cyc();
  endtask

  task automatic test_abort_done();
    bit seen;
    code_mode = MODE_DEC;
    code_din  = 64'hA1A2_A3A4_A5A6_A7A8;
    code_req  = 1'b1;
    start_q.push_back('{CODE_PORT, MODE_DEC, 64'hA1A2_A3A4_A5A6_A7A8});
    wait_start(6, seen);
    e = start_q.pop_front();
    checks++;
    if (!seen || core_din !== e.val || code_gnt !== 1'b1) begin
      errors++;
      $display("FAIL abdone_start: seen=%b din=%h gnt=%b, required 1 %h 1", seen, core_din, code_gnt, e.val);
    end
    core_busy = 1'b1;
    repeat (2) cyc();
    code_abort = 1'b1;
    core_done  = 1'b1;
    core_dout  = 64'hBADB_ADBA_DBAD_BADB;
    cyc();
    code_abort = 1'b0;
    core_done  = 1'b0;
    code_req   = 1'b0;
    checks++;
    if (core_abort !== 1'b1 || code_done !== 1'b0 || dout !== last_res) begin
      errors++;
      $display("FAIL abdone_drain: core_abort=%b code_done=%b dout=%h, required 1 0 %h", core_abort, code_done, dout, last_res);
    end
    cyc();
    core_busy = 1'b0;
    cyc();
    checks++;
    if (core_abort !== 1'b0 || code_done !== 1'b0 || dout !== last_res) begin
      errors++;
      $display("FAIL abdone_exit: core_abort=%b code_done=%b dout=%h, required 0 0 %h", core_abort, code_done, dout, last_res);
    end
  endtask

  task automatic test_abort();
    bit seen;
    bit bad;
    apply_reset();
    data_mode = MODE_ENC;
    data_din  = 64'hD0D1_D2D3_D4D5_D6D7;
    data_req  = 1'b1;
    start_q.push_back('{DATA_PORT, MODE_ENC, 64'hD0D1_D2D3_D4D5_D6D7});
    wait_start(6, seen);
    e = start_q.pop_front();
    checks++;
    if (!seen || core_din !== e.val || core_mode !== e.mode || data_gnt !== 1'b1) begin
      errors++;
      $display("FAIL abort_start: seen=%b din=%h mode=%b gnt=%b, required 1 %h %b 1", seen, core_din, core_mode, data_gnt, e.val, e.mode);
    end
    core_busy = 1'b1;
    repeat (2) cyc();
    code_abort = 1'b1;
    cyc();
    code_abort = 1'b0;
    checks++;
    if (core_abort !== 1'b0 || data_gnt !== 1'b1) begin
      errors++;
      $display("FAIL abort_nonowner: core_abort=%b data_gnt=%b, required 0 1", core_abort, data_gnt);
    end
    repeat (2) cyc();
    data_abort = 1'b1;
    data_req   = 1'b0;
    cyc();
    data_abort = 1'b0;
    bad = (core_abort !== 1'b1);
    repeat (2) begin
      cyc();
      if (core_abort !== 1'b1 || data_done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL abort_hold: core_abort=%b data_done=%b during drain, required 1 0", core_abort, data_done);
    end
    core_busy = 1'b0;
    cyc();
    checks++;
    if (core_abort !== 1'b0 || data_done !== 1'b0 || data_gnt !== 1'b0) begin
      errors++;
      $display("FAIL abort_exit: core_abort=%b data_done=%b data_gnt=%b, required 0 0 0", core_abort, data_done, data_gnt);
    end
    code_mode = MODE_DEC;
    code_din  = 64'h0F0E_0D0C_0B0A_0908;
    code_req  = 1'b1;
    start_q.push_back('{CODE_PORT, MODE_DEC, 64'h0F0E_0D0C_0B0A_0908});
    repeat (2) cyc();
    e = start_q.pop_front();
    checks++;
    if (core_start !== 1'b1 || core_din !== e.val || code_gnt !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle_regrant: core_start=%b din=%h gnt=%b, required 1 %h 1", core_start, core_din, code_gnt, e.val);
    end
    code_req = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic test_timeout();
    bit seen;
    apply_reset();
    code_din = 64'h7777_0000_7777_0000;
    code_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      cyc();
      if (t_core_start === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout_start: t_core_start=%b within 6 cycles, required 1", t_core_start);
    end
    core_busy = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      checks++;
      if (t_timeout_err !== (k == 16) || t_core_abort !== (k == 16)) begin
        errors++;
        $display("FAIL timeout_cycle_%0d: timeout_err=%b core_abort=%b, required %0d %0d",
                 k, t_timeout_err, t_core_abort, (k == 16), (k == 16));
      end
    end
    repeat (2) cyc();
    checks++;
    if (t_core_abort !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hold: core_abort=%b while busy, required 1", t_core_abort);
    end
    core_busy = 1'b0;
    code_req  = 1'b0;
    cyc();
    checks++;
    if (t_core_abort !== 1'b0 || t_timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_exit: core_abort=%b timeout_err=%b, required 0 1", t_core_abort, t_timeout_err);
    end
    repeat (3) cyc();
    checks++;
    if (t_timeout_err !== 1'b1 || t_code_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: timeout_err=%b code_done=%b, required 1 0", t_timeout_err, t_code_done);
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    apply_reset();
    code_mode = MODE_ENC;
    code_din  = 64'hE0E1_E2E3_E4E5_E6E7;
    code_req  = 1'b1;
    start_q.push_back('{CODE_PORT, MODE_ENC, 64'hE0E1_E2E3_E4E5_E6E7});
    wait_start(6, seen);
    e = start_q.pop_front();
    core_busy = 1'b1;
    repeat (3) cyc();
    checks++;
    if (!seen || core_din !== e.val || core_mode !== 1'b1 || code_gnt !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: seen=%b din=%h mode=%b gnt=%b, required 1 %h 1 1", seen, core_din, core_mode, code_gnt, e.val);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({code_gnt, data_gnt, code_done, data_done, core_start, core_mode, core_abort, timeout_err} !== 8'h00
        || core_din !== '0 || dout !== '0) begin
      errors++;
      $display("FAIL arst_outputs: flags=%b din=%h dout=%h, required all zero",
               {code_gnt, data_gnt, code_done, data_done, core_start, core_mode, core_abort, timeout_err}, core_din, dout);
    end
    core_busy = 1'b0;
    cyc();
    reset = 1'b0;
    start_q.push_back('{CODE_PORT, MODE_ENC, 64'hE0E1_E2E3_E4E5_E6E7});
    repeat (2) cyc();
    e = start_q.pop_front();
    checks++;
    if (core_start !== 1'b1 || core_din !== e.val || code_gnt !== 1'b1) begin
      errors++;
      $display("FAIL arst_regrant: core_start=%b din=%h gnt=%b, required 1 %h 1", core_start, core_din, code_gnt, e.val);
    end
    core_busy = 1'b1;
    cyc();
    res_q.push_back('{CODE_PORT, MODE_ENC, 64'h1234_5678_9ABC_DEF0});
    core_done = 1'b1;
    core_dout = 64'h1234_5678_9ABC_DEF0;
    cyc();
    core_done = 1'b0;
    core_busy = 1'b0;
    code_req  = 1'b0;
    e = res_q.pop_front();
    checks++;
    if (code_done !== 1'b1 || dout !== e.val) begin
      errors++;
      $display("FAIL arst_done: code_done=%b dout=%h, required 1 %h", code_done, dout, e.val);
    end
    cyc();
  endtask

  initial begin
    last_res = '0;
    test_reset();
    test_single();
    test_rr();
    test_abort_done();
    test_abort();
    test_timeout();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/cipher_arbiter.md
Name: cipher_arbiter

Overview:
- Shares the single Blowfish cipher core between two requesters: the code-side fetch FSM (port 0) and the data-side load/store FSM (port 1).
- Arbitrates round-robin, launches the core and steers operands to it, then returns the result to the winning requester.
- Handles requester aborts (e.g. branch flush) and a watchdog timeout.
- Sits between the memory-side FSMs and the cipher core. The core's start/abort inputs are driven only by this block.

Parameters:
- DATA_W, 64, cipher block width in bits.
- TIMEOUT, 1023, maximum cycles allowed in RUN before a forced abort.
- CNT_W, 10, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- code_req  in  1  code-side request, level; held until code_done or withdrawn.
- code_mode  in  1  0=decrypt, 1=encrypt.
- code_din  in  DATA_W  code-side operand.
- code_abort  in  1  code-side abort; acts only while code owns the core.
- data_req  in  1  data-side request, level.
- data_mode  in  1  0=decrypt, 1=encrypt.
- data_din  in  DATA_W  data-side operand.
- data_abort  in  1  data-side abort.
- core_busy  in  1  core is processing or draining.
- core_done  in  1  one-cycle pulse; core_dout is valid in the same cycle.
- core_dout  in  DATA_W  core result.
- code_gnt  out  1  code owns the core (GRANT..RESP).
- data_gnt  out  1  data owns the core.
- code_done  out  1  one-cycle pulse; dout valid.
- data_done  out  1  one-cycle pulse; dout valid.
- dout  out  DATA_W  registered result.
- core_start  out  1  one-cycle start pulse to the core.
- core_mode  out  1  registered mode of the owner.
- core_din  out  DATA_W  registered operand of the owner.
- core_abort  out  1  level; held until core_busy=0.
- timeout_err  out  1  sticky; cleared only by reset.

Behaviour:
- Reset: all outputs 0, state IDLE, last_owner=1 (so code wins the first tie), watchdog=0.
- The state register and every output register use async reset. There are no combinational outputs except code_gnt/data_gnt, which are decoded from the owner register and state.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the port that is not last_owner.
  - On grant, latch owner, mode and din into core_mode/core_din, then go to GRANT.
- GRANT (1 cycle): core_start=1, watchdog cleared, go to RUN.
  - Request latency from req to core_start is 2 cycles.
- RUN: watchdog increments every cycle. Priority order:
  1. Owner's abort=1 → core_abort=1, go to DRAIN.
  2. Owner's req=0 (withdrawn) → treated as abort.
  3. watchdog==TIMEOUT → timeout_err=1, core_abort=1, go to DRAIN.
  4. core_done=1 → dout<=core_dout, go to RESP.
  - If abort and core_done occur in the same cycle, abort wins and the result is discarded.
- RESP (1 cycle): owner's done=1, last_owner<=owner, go to IDLE.
  - core_done to requester done latency is 1 cycle.
  - Back-to-back grant is possible on the next IDLE cycle.
- DRAIN: core_abort held at 1 until core_busy=0, then go to IDLE with core_abort=0.
  - No done pulse is issued. last_owner<=owner.
  - core_done arriving during DRAIN is ignored.
- The non-owner's abort is ignored in every state.
- A req that drops while in IDLE before grant is simply not granted.
- Gnt signals are mutually exclusive in every cycle.
- dout holds its value until the next RESP.
- Asserting reset mid-operation returns to IDLE immediately. core_abort goes to 0, so the core must be reset by the same reset.

Decomposition:
- Shared package cipher_pkg holds:
  - state encoding: IDLE=3'b000, GRANT=3'b001, RUN=3'b010, RESP=3'b011, DRAIN=3'b100;
  - port IDs CODE_PORT=1'b0 and DATA_PORT=1'b1;
  - the MODE_DEC/MODE_ENC constants.
- One natural sub-module: rr_arbiter2 (2-way round-robin pick from req[1:0] and last_owner; purely combinational plus a last_owner register).

Test Plan:
- Single code request: code_req=1, code_din=64'h0123456789ABCDEF, core_done after 20 cycles with core_dout=64'hDEADBEEFCAFEF00D → core_start exactly 2 cycles after req, core_din matches, code_done pulses 1 cycle after core_done, dout=64'hDEADBEEFCAFEF00D, data_gnt stays 0.
- Simultaneous requests, three rounds with both reqs held → grants are code, data, code; each core_start carries the owner's din and mode.
- Abort during RUN: data owns, data_abort pulses at cycle 5, core_busy falls 3 cycles later → core_abort high for those cycles, no data_done, and IDLE is reached the cycle after busy=0.
- Abort coinciding with core_done → no done pulse, dout unchanged, DRAIN entered.
- Timeout: TIMEOUT=15, core never signals done → timeout_err=1 at RUN cycle 15, core_abort held until busy=0, timeout_err stays 1 afterwards.
- Async reset asserted mid-RUN (between clock edges) → all outputs 0 immediately; after release, a fresh code_req is granted normally.
